// File: rtl/spike_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : spike_accumulator
//  Description : Sums per-slot partial membrane contributions from N_PE
//                processing elements, integrates each neuron's potential
//                across timesteps, and emits a spike packet per firing neuron
//                followed by a done packet at the end of every timestep.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_accumulator #(
    parameter int               WIDTH      = 64,
    parameter int               N_PE       = 5,
    parameter logic [N_PE*4-1:0] PE_ADDRS  = {4'b1100, 4'b0111, 4'b0011, 4'b0101, 4'b0001},
    parameter int               MP_W       = 13,
    parameter int               SLOTS      = 3,
    parameter int               X_COUNT    = 21,
    parameter int               THRESHOLD  = 64,
    parameter int               RESET_MODE = 0,
    parameter logic [4:0]       ADDER_NUM  = 5'd0,
    parameter int               Y_STRIDE   = 7,
    parameter logic [3:0]       DEST_ADDR  = 4'b1010,
    parameter logic [3:0]       SRC_ADDR   = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_drop
);

    localparam int c_NEURONS = X_COUNT * SLOTS;
    localparam int c_K_W     = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam int c_S_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int c_C_W     = $clog2(SLOTS + 1);
    localparam int c_X_W     = (X_COUNT > 1) ? $clog2(X_COUNT) : 1;
    localparam int c_N_W     = (c_NEURONS > 1) ? $clog2(c_NEURONS) : 1;
    localparam int c_SUM_W   = MP_W + $clog2(N_PE);
    localparam int c_V_W     = c_SUM_W + 1;
    localparam int c_PAD_W   = WIDTH - 20;
    localparam logic [MP_W-1:0] c_MP_MAX = '1;
    localparam logic [31:0]     c_THRESH = THRESHOLD;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ACCUM   = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_stateNext;
    state_t w_advTarget;

    logic [c_C_W-1:0] r_cnt [N_PE];
    logic [MP_W-1:0]  r_buf [N_PE][SLOTS];
    logic [MP_W-1:0]  r_mem [c_NEURONS];
    logic [c_S_W-1:0] r_s;
    logic [c_X_W-1:0] r_x;
    logic             r_firstTs;
    logic             r_clearPend;
    logic [WIDTH-1:0] r_outData;
    logic             r_errDrop;

    logic             w_accept;
    logic             w_hit;
    logic [c_K_W-1:0] w_hitIdx;
    logic             w_hitFull;
    logic             w_store;
    logic             w_drop;
    logic [c_S_W-1:0] w_slotIdx;
    logic             w_allFullNext;
    logic [c_SUM_W-1:0] w_sum;
    logic [c_V_W-1:0] w_vWide;
    logic [MP_W-1:0]  w_v;
    logic [MP_W-1:0]  w_residue;
    logic [c_N_W-1:0] w_n;
    logic             w_fire;
    logic             w_lastSlot;
    logic             w_lastRound;
    logic             w_advance;
    logic             w_enterCollect;
    logic             w_enterDone;
    logic             w_doClear;
    logic [4:0]       w_xField;
    logic [4:0]       w_yField;
    logic             w_unused;

    assign w_unused = ^{in_data[WIDTH-1:60], in_data[55:MP_W]};

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == EMIT) || (r_state == DONE);
    assign out_data  = r_outData;
    assign err_drop  = r_errDrop;

    // Input decode: match source address, decide store versus drop, and
    // predict whether this accept completes the round.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int k = N_PE - 1; k >= 0; k--) begin
            if (in_data[59:56] == PE_ADDRS[k*4 +: 4]) begin
                w_hit    = 1'b1;
                w_hitIdx = c_K_W'(k);
            end
        end
        w_accept  = in_valid && (r_state == COLLECT);
        w_hitFull = (r_cnt[w_hitIdx] == c_C_W'(SLOTS));
        w_slotIdx = c_S_W'(r_cnt[w_hitIdx]);
        w_store   = w_accept && w_hit && !w_hitFull;
        w_drop    = w_accept && (!w_hit || w_hitFull);
        w_allFullNext = 1'b1;
        for (int k = 0; k < N_PE; k++) begin
            if (!((r_cnt[k] == c_C_W'(SLOTS)) ||
                  (w_store && (w_hitIdx == c_K_W'(k)) && (r_cnt[k] == c_C_W'(SLOTS - 1)))))
                w_allFullNext = 1'b0;
        end
    end

    // Slot reduction, membrane integration with saturation, and fire decision.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N_PE; k++)
            w_sum = w_sum + c_SUM_W'(r_buf[k][r_s]);
        w_n     = c_N_W'(r_x) * c_N_W'(SLOTS) + c_N_W'(r_s);
        w_vWide = r_firstTs ? c_V_W'(w_sum) : (c_V_W'(r_mem[w_n]) + c_V_W'(w_sum));
        w_v     = (w_vWide > c_V_W'(c_MP_MAX)) ? c_MP_MAX : w_vWide[MP_W-1:0];
        w_fire  = ({{(32-MP_W){1'b0}}, w_v} > c_THRESH);
        w_residue = (RESET_MODE == 1) ? '0 : (w_v - c_THRESH[MP_W-1:0]);
        w_xField  = 5'(r_x);
        w_yField  = 5'(r_s) * 5'(Y_STRIDE) + ADDER_NUM;
    end

    // Next-state logic, including where a completed slot goes next.
    always_comb begin
        w_lastSlot  = (r_s == c_S_W'(SLOTS - 1));
        w_lastRound = (r_x == c_X_W'(X_COUNT - 1));
        w_advance   = ((r_state == ACCUM) && !w_fire) || ((r_state == EMIT) && out_ready);
        if (!w_lastSlot)
            w_advTarget = ACCUM;
        else if (w_lastRound)
            w_advTarget = DONE;
        else
            w_advTarget = COLLECT;
        w_stateNext = r_state;
        case (r_state)
            COLLECT: if (!clear && w_allFullNext) w_stateNext = ACCUM;
            ACCUM:   w_stateNext = w_fire ? EMIT : w_advTarget;
            EMIT:    if (out_ready) w_stateNext = w_advTarget;
            DONE:    if (clear || out_ready) w_stateNext = COLLECT;
            default: w_stateNext = COLLECT;
        endcase
        w_enterCollect = (w_stateNext == COLLECT) && (r_state != COLLECT);
        w_enterDone    = (w_stateNext == DONE) && (r_state != DONE);
        // A clear seen while computing is deferred until the round returns
        // to COLLECT, so no partially emitted round is torn apart.
        w_doClear = (clear && ((r_state == COLLECT) || (r_state == DONE))) ||
                    ((r_clearPend || (clear && ((r_state == ACCUM) || (r_state == EMIT))))
                     && w_enterCollect);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= COLLECT;
        else
            r_state <= w_stateNext;
    end

    // Round/slot counters, timestep flag, pending clear and output packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '{default: '0};
            r_s         <= '0;
            r_x         <= '0;
            r_firstTs   <= 1'b1;
            r_clearPend <= 1'b0;
            r_outData   <= '0;
            r_errDrop   <= 1'b0;
        end else begin
            r_errDrop <= w_drop;
            if (w_store)
                r_cnt[w_hitIdx] <= r_cnt[w_hitIdx] + 1'b1;
            if ((r_state == ACCUM) && w_fire)
                r_outData <= {DEST_ADDR, SRC_ADDR, 2'b11, {c_PAD_W{1'b0}}, w_xField, w_yField};
            if (w_enterDone)
                r_outData <= {DEST_ADDR, SRC_ADDR, 2'b11, {c_PAD_W{1'b0}}, 10'h3FF};
            if (w_advance) begin
                if (!w_lastSlot) begin
                    r_s <= r_s + 1'b1;
                end else begin
                    r_cnt <= '{default: '0};
                    r_s   <= '0;
                    if (!w_lastRound)
                        r_x <= r_x + 1'b1;
                end
            end
            if ((r_state == DONE) && out_ready) begin
                r_x       <= '0;
                r_firstTs <= 1'b0;
            end
            if (w_enterCollect)
                r_clearPend <= 1'b0;
            else if (clear && ((r_state == ACCUM) || (r_state == EMIT)))
                r_clearPend <= 1'b1;
            if (w_doClear) begin
                r_cnt     <= '{default: '0};
                r_s       <= '0;
                r_x       <= '0;
                r_firstTs <= 1'b1;
            end
        end
    end

    // Partial-sum buffers and residue memory; contents are qualified by the
    // counters and first-timestep flag, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_store)
            r_buf[w_hitIdx][w_slotIdx] <= in_data[MP_W-1:0];
        if (r_state == ACCUM)
            r_mem[w_n] <= w_fire ? w_residue : w_v;
        if (w_doClear) begin
            for (int k = 0; k < N_PE; k++)
                for (int j = 0; j < SLOTS; j++)
                    r_buf[k][j] <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_accumulator
//  Description : Self-checking bench for spike_accumulator. Two instances:
//                subtract-on-fire and reset-to-zero modes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_accumulator;

    logic            clk = 1'b0;
    logic [1:0]      rstN;
    logic [1:0]      clr;
    logic [1:0]      inValid;
    logic [1:0]      inReady;
    logic [1:0][63:0] inData;
    logic [1:0]      outValid;
    logic [1:0]      outReady;
    logic [1:0][63:0] outData;
    logic [1:0]      errDrop;

    int nChecks = 0;
    int nPass   = 0;
    int spikeCnt[2];
    int dropCnt[2];
    bit prevStall[2];
    logic [63:0] prevData[2];

    logic [63:0] expQ0[$];
    logic [63:0] expQ1[$];
    int unsigned mdlMem[2][63];
    bit          mdlFirst[2];
    int          mdlX[2];

    logic [3:0] peAddr[5] = '{4'b0001, 4'b0101, 4'b0011, 4'b0111, 4'b1100};

    typedef struct {
        int d;
        int partial;
        bit drops;
        int expSpk;
        int expDrops;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    spike_accumulator #(.RESET_MODE(0)) dut (
        .clk(clk), .rst_n(rstN[0]), .clear(clr[0]),
        .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
        .err_drop(errDrop[0])
    );

    spike_accumulator #(.RESET_MODE(1)) dutSat (
        .clk(clk), .rst_n(rstN[1]), .clear(clr[1]),
        .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
        .err_drop(errDrop[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] spikePkt(input int x, input int s);
        logic [4:0] xf;
        logic [4:0] yf;
        xf = 5'(x);
        yf = 5'(s * 7);
        return {4'hA, 4'h0, 2'b11, 44'd0, xf, yf};
    endfunction

    function automatic void pushExp(input int d, input logic [63:0] p);
        if (d == 0) expQ0.push_back(p);
        else expQ1.push_back(p);
    endfunction

    // Reference behaviour of one round with identical partials from all PEs.
    function automatic void modelRound(input int d, input int partial);
        int sum, v, n;
        for (int s = 0; s < 3; s++) begin
            n   = mdlX[d] * 3 + s;
            sum = 5 * partial;
            v   = mdlFirst[d] ? sum : int'(mdlMem[d][n]) + sum;
            if (v > 8191) v = 8191;
            if (v > 64) begin
                pushExp(d, spikePkt(mdlX[d], s));
                mdlMem[d][n] = (d == 1) ? 0 : v - 64;
            end else begin
                mdlMem[d][n] = v;
            end
        end
        if (mdlX[d] == 20) begin
            pushExp(d, 64'hA0C0_0000_0000_03FF);
            mdlX[d]     = 0;
            mdlFirst[d] = 1'b0;
        end else begin
            mdlX[d]++;
        end
    endfunction

    function automatic void modelClear(input int d);
        mdlX[d]     = 0;
        mdlFirst[d] = 1'b1;
    endfunction

    task automatic sendPkt(input int d, input logic [3:0] src, input int val);
        int budget;
        budget = 0;
        @(negedge clk);
        inValid[d] = 1'b1;
        inData[d]  = {4'h0, src, 43'd0, 13'(val)};
        while (!inReady[d] && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (!inReady[d]) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        inValid[d] = 1'b0;
    endtask

    task automatic waitIdle(input int d);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!inReady[d] && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (!inReady[d]) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitValid(input int d);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!outValid[d] && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!outValid[d]) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic sendRoundPkts(input int d, input int partial, input bit drops);
        modelRound(d, partial);
        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 3; s++) begin
                sendPkt(d, peAddr[k], partial);
                if (drops && k == 0 && s == 2) begin
                    sendPkt(d, 4'b0001, 999);
                    sendPkt(d, 4'b1111, 777);
                end
            end
        end
    endtask

    task automatic runRound(input int d, input int partial, input bit drops,
                            input int expSpk, input int expDrops, input string name);
        int s0, d0;
        s0 = spikeCnt[d];
        d0 = dropCnt[d];
        sendRoundPkts(d, partial, drops);
        waitIdle(d);
        check({name, "_spikes"}, 64'(spikeCnt[d] - s0), 64'(expSpk));
        check({name, "_drops"},  64'(dropCnt[d] - d0),  64'(expDrops));
    endtask

    // Output monitor: scoreboard pops on handshake, stability under stall.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rstN[d]) begin
                prevStall[d] = 1'b0;
            end else begin
                if (errDrop[d]) dropCnt[d]++;
                if (prevStall[d]) begin
                    check("stall_valid", 64'(outValid[d]), 64'd1);
                    check("stall_data", outData[d], prevData[d]);
                end
                if (outValid[d] && outReady[d]) begin
                    if ((d == 0 && expQ0.size() == 0) || (d == 1 && expQ1.size() == 0)) begin
                        check("unexpected_pkt", outData[d], 64'd0);
                    end else if (d == 0) begin
                        check("pkt0", outData[d], expQ0.pop_front());
                    end else begin
                        check("pkt1", outData[d], expQ1.pop_front());
                    end
                    if (outData[d][9:0] != 10'h3FF) spikeCnt[d]++;
                end
                prevStall[d] = outValid[d] && !outReady[d];
                prevData[d]  = outData[d];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 2'b00; clr = 2'b00; inValid = 2'b00; inData = '0; outReady = 2'b11;
        for (int d = 0; d < 2; d++) begin
            spikeCnt[d] = 0; dropCnt[d] = 0; mdlX[d] = 0; mdlFirst[d] = 1'b1;
            prevStall[d] = 1'b0; prevData[d] = '0;
        end

        // Vector table: {dut, partial, inject drops, spikes expected, drops expected}.
        for (int i = 0; i < 21; i++) vecs.push_back('{0, 20, 1'b0, 3, 0});
        vecs.push_back('{0, 20, 1'b0, 3, 0});   // 36+100=136 fires
        vecs.push_back('{0,  0, 1'b0, 0, 0});   // 36 stays
        vecs.push_back('{0,  5, 1'b0, 0, 0});   // 61 below threshold
        vecs.push_back('{0,  6, 1'b0, 3, 0});   // 66 just above
        vecs.push_back('{0,  1, 1'b0, 0, 0});   // 41
        for (int i = 5; i < 21; i++) vecs.push_back('{0, 20, 1'b0, 3, 0});
        vecs.push_back('{0, 20, 1'b1, 3, 2});   // 72+100 with two dropped packets
        for (int i = 0; i < 21; i++) vecs.push_back('{1, 8191, 1'b0, 3, 0});
        vecs.push_back('{1, 12, 1'b0, 0, 0});   // residue 0 + 60, no fire

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_out_valid", 64'(outValid[d]), 64'd0);
            check("rst_out_data",  outData[d], 64'd0);
            check("rst_err_drop",  64'(errDrop[d]), 64'd0);
            check("rst_in_ready",  64'(inReady[d]), 64'd1);
        end
        rstN = 2'b11;

        for (int i = 0; i < vecs.size(); i++)
            runRound(vecs[i].d, vecs[i].partial, vecs[i].drops,
                     vecs[i].expSpk, vecs[i].expDrops, $sformatf("row%0d", i));

        // Backpressure with a clear arriving during EMIT.
        outReady[0] = 1'b0;
        begin
            int s0;
            s0 = spikeCnt[0];
            sendRoundPkts(0, 20, 1'b0);
            waitValid(0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("bp_in_ready", 64'(inReady[0]), 64'd0);
                check("bp_out_valid", 64'(outValid[0]), 64'd1);
                if (i == 3) clr[0] = 1'b1;
                if (i == 4) clr[0] = 1'b0;
            end
            outReady[0] = 1'b1;
            waitIdle(0);
            check("bp_spikes", 64'(spikeCnt[0] - s0), 64'd3);
        end
        modelClear(0);
        runRound(0, 12, 1'b0, 0, 0, "latched_clear");
        runRound(0, 20, 1'b0, 3, 0, "after_clear_x1");

        // Clear in COLLECT with a partly filled round.
        sendPkt(0, 4'b0001, 5000);
        sendPkt(0, 4'b0001, 5000);
        @(negedge clk) clr[0] = 1'b1;
        @(negedge clk) clr[0] = 1'b0;
        modelClear(0);
        runRound(0, 12, 1'b0, 0, 0, "collect_clear");

        // Asynchronous reset while a spike is stalled in EMIT.
        outReady[0] = 1'b0;
        sendRoundPkts(0, 20, 1'b0);
        waitValid(0);
        #2 rstN[0] = 1'b0;
        #1 check("rst_emit_valid", 64'(outValid[0]), 64'd0);
        expQ0.delete();
        modelClear(0);
        @(negedge clk);
        @(negedge clk);
        rstN[0] = 1'b1;
        outReady[0] = 1'b1;
        check("rst2_out_data", outData[0], 64'd0);
        check("rst2_in_ready", 64'(inReady[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst2_no_valid", 64'(outValid[0]), 64'd0);
        end
        runRound(0, 20, 1'b0, 3, 0, "after_reset");

        repeat (3) @(negedge clk);
        check("q0_empty", 64'(expQ0.size()), 64'd0);
        check("q1_empty", 64'(expQ1.size()), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
